// File: rtl/skel_pkg.sv
// Shared encodings for the cycle sequencer: FSM states, opcodes, mux selects,
// overflow status codes and the decoded opcode-class payload.
package skel_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OP_W-1:0] OP_J     = 5'b00001;
  localparam logic [OP_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW    = 5'b01000;

  localparam logic [OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'b00001;

  typedef enum logic [SEL_W-1:0] {
    PC_PLUS1  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  typedef enum logic [SEL_W-1:0] {
    WB_ALU    = 2'b00,
    WB_DMEM   = 2'b01,
    WB_STATUS = 2'b10
  } wb_sel_e;

  localparam logic [CODE_W-1:0] RS_NONE = 2'd0;
  localparam logic [CODE_W-1:0] RS_ADD  = 2'd1;
  localparam logic [CODE_W-1:0] RS_ADDI = 2'd2;
  localparam logic [CODE_W-1:0] RS_SUB  = 2'd3;

  typedef struct packed {
    logic rtype;
    logic addi;
    logic lw;
    logic sw;
    logic j;
    logic bne;
    logic illegal;
    logic is_sub;
    logic is_add;
  } op_class_t;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Instruction-in / strobe-out bundle between the sequencer and its datapath.
interface cycle_sequencer_if;
  import skel_pkg::*;

  logic [OP_W-1:0]   opcode;
  logic [OP_W-1:0]   alu_op;
  logic              alu_ovf;
  logic              br_taken;
  logic              halt_req;

  logic              imem_en;
  logic              alu_en;
  logic              dmem_en;
  logic              dmem_we;
  logic              rf_we;
  logic              pc_en;
  logic [SEL_W-1:0]  pc_sel;
  logic [SEL_W-1:0]  wb_sel;
  logic [CODE_W-1:0] rstatus_code;
  logic [ST_W-1:0]   state;
  logic              illegal;
  logic [CNT_W-1:0]  instr_retired;

  modport master (
    output opcode, alu_op, alu_ovf, br_taken, halt_req,
    input  imem_en, alu_en, dmem_en, dmem_we, rf_we, pc_en,
    input  pc_sel, wb_sel, rstatus_code, state, illegal, instr_retired
  );

  modport slave (
    input  opcode, alu_op, alu_ovf, br_taken, halt_req,
    output imem_en, alu_en, dmem_en, dmem_we, rf_we, pc_en,
    output pc_sel, wb_sel, rstatus_code, state, illegal, instr_retired
  );

endinterface

// File: rtl/seq_decode.sv
// Combinational opcode / alu_op classifier feeding the sequencer FSM.
module seq_decode
  import skel_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] alu_op,
  output op_class_t       cls_c
);

  always_comb begin
    cls_c        = '0;
    cls_c.is_add = (alu_op == ALU_ADD);
    cls_c.is_sub = (alu_op == ALU_SUB);
    case (opcode)
      OP_RTYPE: cls_c.rtype   = 1'b1;
      OP_ADDI:  cls_c.addi    = 1'b1;
      OP_LW:    cls_c.lw      = 1'b1;
      OP_SW:    cls_c.sw      = 1'b1;
      OP_J:     cls_c.j       = 1'b1;
      OP_BNE:   cls_c.bne     = 1'b1;
      default:  cls_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB phase strobes.
// Optional build macro SEQ_PERF_CNT_EN adds the retired-instruction counter.
module cycle_sequencer
  import skel_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  cycle_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  op_class_t         dec_c, cls_q;
  logic              ovf_q;
  logic              illegal_q;
  logic              final_c;
  logic              ovf_wb_c;

  logic              imem_en_c, alu_en_c, dmem_en_c, dmem_we_c, rf_we_c;
  pc_sel_e           pc_sel_c;
  wb_sel_e           wb_sel_c;
  logic [CODE_W-1:0] rstatus_c;

  seq_decode u_decode (
    .opcode (bus.opcode),
    .alu_op (bus.alu_op),
    .cls_c  (dec_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Opcode class held from DECODE on; overflow flag captured in EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cls_q     <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == ST_DECODE) begin
        cls_q <= dec_c;
        if (dec_c.illegal) illegal_q <= 1'b1;
      end
      if (state_q == ST_EXEC) ovf_q <= bus.alu_ovf;
    end
  end

  always_comb begin
    state_d = state_q;
    final_c = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_c.illegal) final_c = 1'b1;
        else               state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_q.j || cls_q.bne || cls_q.illegal) final_c = 1'b1;
        else if (cls_q.lw || cls_q.sw)             state_d = ST_MEM;
        else                                       state_d = ST_WB;
      end
      ST_MEM: begin
        if (cls_q.sw) final_c = 1'b1;
        else          state_d = ST_WB;
      end
      ST_WB:     final_c = 1'b1;
      ST_HALT: begin
        if (!bus.halt_req) state_d = ST_FETCH;
      end
      default:   state_d = ST_IDLE;
    endcase
    // halt_req only matters once the current instruction has finished
    if (final_c) state_d = bus.halt_req ? ST_HALT : ST_FETCH;
  end

  assign ovf_wb_c = ovf_q && (cls_q.addi || (cls_q.rtype && (cls_q.is_add || cls_q.is_sub)));

  always_comb begin
    imem_en_c = 1'b0;
    alu_en_c  = 1'b0;
    dmem_en_c = 1'b0;
    dmem_we_c = 1'b0;
    rf_we_c   = 1'b0;
    pc_sel_c  = PC_PLUS1;
    wb_sel_c  = WB_ALU;
    rstatus_c = RS_NONE;
    case (state_q)
      ST_FETCH: imem_en_c = 1'b1;
      ST_EXEC: begin
        alu_en_c = 1'b1;
        if (cls_q.j)                        pc_sel_c = PC_JUMP;
        else if (cls_q.bne && bus.br_taken) pc_sel_c = PC_BRANCH;
      end
      ST_MEM: begin
        dmem_en_c = 1'b1;
        dmem_we_c = cls_q.sw;
      end
      ST_WB: begin
        rf_we_c = 1'b1;
        // Overflow redirects the single register write to the status register
        if (ovf_wb_c) begin
          wb_sel_c  = WB_STATUS;
          rstatus_c = cls_q.addi ? RS_ADDI : (cls_q.is_sub ? RS_SUB : RS_ADD);
        end else if (cls_q.lw) begin
          wb_sel_c  = WB_DMEM;
        end
      end
      default: ;
    endcase
  end

  assign bus.imem_en      = imem_en_c;
  assign bus.alu_en       = alu_en_c;
  assign bus.dmem_en      = dmem_en_c;
  assign bus.dmem_we      = dmem_we_c;
  assign bus.rf_we        = rf_we_c;
  assign bus.pc_en        = final_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.rstatus_code = rstatus_c;
  assign bus.state        = state_q;
  assign bus.illegal      = illegal_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      retired_q <= '0;
    else if (final_c) retired_q <= retired_q + CNT_W'(1);
  end

  assign bus.instr_retired = retired_q;
`else
  assign bus.instr_retired = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: instruction table plus halt/reset corner sequences.
module tb_cycle_sequencer;
  import skel_pkg::*;

  typedef struct {
    string      name;
    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic       ovf;
    logic       br;
    int         cycles;
    logic [2:0] fin_state;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic [1:0] code;
    int         rf_we;
    int         dmem_en;
    int         dmem_we;
    int         alu_en;
    logic       sets_ill;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cycle_sequencer_if bus ();

  cycle_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_retired = 0;
  logic exp_ill = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ret_exp();
`ifdef SEQ_PERF_CNT_EN
    return longint'(exp_retired);
`else
    return 0;
`endif
  endfunction

  task automatic add_vec(input string nm, input logic [4:0] op, input logic [4:0] aop,
                         input logic ovf, input logic br, input int cyc, input logic [2:0] fs,
                         input logic [1:0] ps, input logic [1:0] ws, input logic [1:0] cd,
                         input int rf, input int den, input int dwe, input int alu,
                         input logic ill);
    vec_t v;
    v.name = nm; v.opcode = op; v.alu_op = aop; v.ovf = ovf; v.br = br;
    v.cycles = cyc; v.fin_state = fs; v.pc_sel = ps; v.wb_sel = ws; v.code = cd;
    v.rf_we = rf; v.dmem_en = den; v.dmem_we = dwe; v.alu_en = alu; v.sets_ill = ill;
    vecs.push_back(v);
  endtask

  // Called at a negedge in IDLE or an instruction's final state
  task automatic run_instr(input vec_t v);
    vec_t       e;
    int         cyc, rf, den, dwe, alu;
    logic       done;
    logic [2:0] fs;
    logic [1:0] ps, ws, cs;
    cyc = 0; rf = 0; den = 0; dwe = 0; alu = 0; done = 1'b0;
    fs = '0; ps = '0; ws = '0; cs = '0;
    @(posedge clock); #1;
    bus.opcode = v.opcode; bus.alu_op = v.alu_op;
    bus.alu_ovf = v.ovf;   bus.br_taken = v.br;
    sb_q.push_back(v);
    while (!done && cyc < 12) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk({v.name, " fetch_state"}, longint'(bus.state), longint'(ST_FETCH));
        chk({v.name, " retired"}, longint'(bus.instr_retired), ret_exp());
        chk({v.name, " illegal_flag"}, longint'(bus.illegal), longint'(exp_ill));
      end
      rf  += int'(bus.rf_we);
      den += int'(bus.dmem_en);
      dwe += int'(bus.dmem_we);
      alu += int'(bus.alu_en);
      if (bus.pc_en) begin
        done = 1'b1;
        fs = bus.state; ps = bus.pc_sel; ws = bus.wb_sel; cs = bus.rstatus_code;
      end
    end
    e = sb_q.pop_front();
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no pc_en within %0d cycles", e.name, cyc);
    end else begin
      chk({e.name, " cycles"},  longint'(cyc), longint'(e.cycles));
      chk({e.name, " final_state"}, longint'(fs), longint'(e.fin_state));
      chk({e.name, " pc_sel"},  longint'(ps),  longint'(e.pc_sel));
      chk({e.name, " wb_sel"},  longint'(ws),  longint'(e.wb_sel));
      chk({e.name, " rstatus"}, longint'(cs),  longint'(e.code));
      chk({e.name, " rf_we_cnt"}, longint'(rf),  longint'(e.rf_we));
      chk({e.name, " dmem_en_cnt"}, longint'(den), longint'(e.dmem_en));
      chk({e.name, " dmem_we_cnt"}, longint'(dwe), longint'(e.dmem_we));
      chk({e.name, " alu_en_cnt"}, longint'(alu), longint'(e.alu_en));
      exp_retired++;
      if (e.sets_ill) exp_ill = 1'b1;
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {bus.imem_en, bus.alu_en, bus.dmem_en, bus.dmem_we, bus.rf_we, bus.pc_en,
            bus.pc_sel, bus.wb_sel, bus.rstatus_code, bus.illegal, bus.state};
  endfunction

  initial begin
    bus.opcode = '0; bus.alu_op = '0; bus.alu_ovf = 1'b0;
    bus.br_taken = 1'b0; bus.halt_req = 1'b0;

    //        name        opcode    alu_op    ovf br cyc final      pc  wb  cd  rf den dwe alu ill
    add_vec("addi",      5'b00101, 5'b00000, 0, 0, 4, ST_WB,     0,  0,  0,  1, 0,  0,  1,  0);
    add_vec("sub_ovf",   5'b00000, 5'b00001, 1, 0, 4, ST_WB,     0,  2,  3,  1, 0,  0,  1,  0);
    add_vec("addi_ovf",  5'b00101, 5'b00000, 1, 0, 4, ST_WB,     0,  2,  2,  1, 0,  0,  1,  0);
    add_vec("add_ovf",   5'b00000, 5'b00000, 1, 0, 4, ST_WB,     0,  2,  1,  1, 0,  0,  1,  0);
    add_vec("add",       5'b00000, 5'b00000, 0, 0, 4, ST_WB,     0,  0,  0,  1, 0,  0,  1,  0);
    add_vec("rother_ovf",5'b00000, 5'b00011, 1, 0, 4, ST_WB,     0,  0,  0,  1, 0,  0,  1,  0);
    add_vec("lw_ovf",    5'b01000, 5'b00000, 1, 0, 5, ST_WB,     0,  1,  0,  1, 1,  0,  1,  0);
    add_vec("sw",        5'b00111, 5'b00000, 0, 0, 4, ST_MEM,    0,  0,  0,  0, 1,  1,  1,  0);
    add_vec("bne_taken", 5'b00010, 5'b00000, 0, 1, 3, ST_EXEC,   1,  0,  0,  0, 0,  0,  1,  0);
    add_vec("bne_not",   5'b00010, 5'b00000, 0, 0, 3, ST_EXEC,   0,  0,  0,  0, 0,  0,  1,  0);
    add_vec("j",         5'b00001, 5'b00000, 0, 1, 3, ST_EXEC,   2,  0,  0,  0, 0,  0,  1,  0);
    add_vec("illegal",   5'b11111, 5'b00000, 1, 0, 2, ST_DECODE, 0,  0,  0,  0, 0,  0,  0,  1);
    add_vec("after_ill", 5'b00101, 5'b00000, 0, 0, 4, ST_WB,     0,  0,  0,  1, 0,  0,  1,  0);

    // Reset held low for two cycles
    #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("reset_outs", longint'(all_outs()), 0);
      chk("reset_retired", longint'(bus.instr_retired), 0);
    end
    reset = 1'b1;
    #1 chk("release_idle", longint'(bus.state), longint'(ST_IDLE));

    foreach (vecs[i]) run_instr(vecs[i]);

    // Halt raised during EXEC of addi: WB completes, then HALT until released
    @(posedge clock); #1;
    bus.opcode = OP_ADDI; bus.alu_op = ALU_ADD; bus.alu_ovf = 1'b0; bus.br_taken = 1'b0;
    @(negedge clock); chk("halt fetch", longint'(bus.state), longint'(ST_FETCH));
    @(negedge clock);
    @(negedge clock); chk("halt exec", longint'(bus.state), longint'(ST_EXEC));
    bus.halt_req = 1'b1;
    @(negedge clock);
    chk("halt wb_state", longint'(bus.state), longint'(ST_WB));
    chk("halt wb_pc_en", longint'(bus.pc_en), 1);
    exp_retired++;
    @(negedge clock);
    chk("halt state", longint'(bus.state), longint'(ST_HALT));
    chk("halt strobes", longint'({bus.imem_en, bus.alu_en, bus.dmem_en, bus.dmem_we,
                                  bus.rf_we, bus.pc_en}), 0);
    @(negedge clock);
    chk("halt hold", longint'(bus.state), longint'(ST_HALT));
    bus.halt_req = 1'b0;
    bus.opcode = OP_SW;
    @(negedge clock);
    chk("halt resume_fetch", longint'(bus.state), longint'(ST_FETCH));
    chk("halt resume_imem", longint'(bus.imem_en), 1);
    chk("halt retired", longint'(bus.instr_retired), ret_exp());

    // Reset pulled mid-MEM of sw must drop dmem_we with no clock edge
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("sw mem_state", longint'(bus.state), longint'(ST_MEM));
    chk("sw mem_we", longint'(bus.dmem_we), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid dmem_we", longint'(bus.dmem_we), 0);
    chk("rst_mid state", longint'(bus.state), longint'(ST_IDLE));
    chk("rst_mid outs", longint'(all_outs()), 0);
    chk("rst_mid illegal", longint'(bus.illegal), 0);
    chk("rst_mid retired", longint'(bus.instr_retired), 0);
    @(negedge clock);
    reset = 1'b1;
    exp_retired = 0;
    exp_ill = 1'b0;
    #1 chk("rerelease_idle", longint'(bus.state), longint'(ST_IDLE));
    run_instr(vecs[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Port clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Port reset  in  1  asynchronous, active-low reset.
REQ-003 Port opcode  in  5  instruction bits [31:27] from imem q.
REQ-004 Port alu_op  in  5  instruction bits [6:2]; selects add 00000 / sub 00001 for R-type.
REQ-005 Port alu_ovf  in  1  ALU overflow flag, valid in EXEC.
REQ-006 Port br_taken  in  1  bne compare result (operands unequal), valid in EXEC.
REQ-007 Port halt_req  in  1  level request to stop issuing instructions.
REQ-008 Port imem_en, alu_en, dmem_en, dmem_we, rf_we, pc_en  out  1 each  per-phase strobes.
REQ-009 Port pc_sel  out  2  00 PC+1, 01 branch target, 10 jump target.
REQ-010 Port wb_sel  out  2  00 ALU, 01 dmem, 10 status ($30 with rstatus_code).
REQ-011 Port rstatus_code  out  2  overflow code: 1 add, 2 addi, 3 sub.
REQ-012 Port state  out  3  current FSM state, for debug.
REQ-013 Port illegal  out  1  sticky flag: unrecognised opcode seen.
REQ-014 Port instr_retired  out  32  retired-instruction count (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 IDLE SHALL go to FETCH on the first edge after reset release.
REQ-017 FETCH SHALL assert imem_en and go to DECODE; DECODE SHALL register the opcode class and go to EXEC.
REQ-018 EXEC SHALL assert alu_en and register alu_ovf into an internal ovf flag.
REQ-019 R-type (00000) and addi (00101) SHALL sequence FETCH-DECODE-EXEC-WB (4 cycles).
REQ-020 lw (01000) SHALL sequence FETCH-DECODE-EXEC-MEM-WB (5 cycles); MEM asserts dmem_en only; WB uses wb_sel=01.
REQ-021 sw (00111) SHALL sequence FETCH-DECODE-EXEC-MEM (4 cycles); MEM asserts dmem_en and dmem_we; sw never asserts rf_we.
REQ-022 j (00001) SHALL end in EXEC with pc_en=1 and pc_sel=10 (3 cycles).
REQ-023 bne (00010) SHALL end in EXEC with pc_en=1 and pc_sel=01 if br_taken, else 00 (3 cycles).
REQ-024 pc_en SHALL pulse exactly once per instruction, in its final state; pc_sel=00 except as in REQ-022/023.
REQ-025 In WB with ovf flag set for add/addi/sub, the sequencer SHALL set wb_sel=10 and rstatus_code 1/2/3; rf_we is asserted once, and the rd write is replaced by the $30 write.
REQ-026 An unrecognised opcode SHALL set illegal, execute as a no-op (pc_en in DECODE), and take 2 cycles.
REQ-027 halt_req SHALL be sampled only in the final state of an instruction; if high, the next state is HALT rather than FETCH, and the current instruction completes.
REQ-028 HALT SHALL drive all strobes low and return to FETCH on the first edge after halt_req is low.
REQ-029 Strobes SHALL be Moore outputs decoded from state, except pc_sel, which depends on br_taken.

Reset
REQ-030 Reset assertion SHALL force IDLE immediately, from any state.
REQ-031 During reset, all strobes, pc_sel, wb_sel, rstatus_code, illegal and instr_retired SHALL be 0, and state SHALL be IDLE.
REQ-032 Reset asserted mid-MEM SHALL drop dmem_we combinationally, with no clock needed.

Configuration
REQ-033 With SEQ_PERF_CNT_EN defined, instr_retired SHALL increment on every pc_en pulse and wrap from 0xFFFFFFFF to 0.
REQ-034 Without SEQ_PERF_CNT_EN, instr_retired SHALL be constant 0 and no counter flops are built.

Structure
REQ-035 Package skel_pkg SHALL hold the state encodings, opcode constants, pc_sel/wb_sel encodings and rstatus codes.
REQ-036 Sub-module seq_decode SHALL be the combinational opcode/alu_op classifier (rtype, addi, lw, sw, j, bne, illegal, is_sub).

Verification
REQ-037 Reset low 2 cycles, then released -> IDLE, then FETCH with imem_en=1 and pc_en=0.
REQ-038 opcode=00101, alu_ovf=0 -> states F,D,E,W; rf_we=1, wb_sel=00 and pc_en=1 in cycle 4; instr_retired=1 when the macro is defined.
REQ-039 opcode=00000, alu_op=00001, alu_ovf=1 -> WB wb_sel=10, rstatus_code=3, single rf_we; repeat with addi -> code 2.
REQ-040 opcode=01000 -> dmem_en=1, dmem_we=0 in MEM, wb_sel=01 in WB (5 cycles); opcode=00111 -> dmem_we=1 in MEM, rf_we never asserted (4 cycles).
REQ-041 opcode=00010 with br_taken=1 -> pc_sel=01, pc_en=1 in cycle 3; opcode=00001 -> pc_sel=10 in cycle 3.
REQ-042 halt_req=1 raised during EXEC of addi -> WB completes, HALT entered, FETCH one cycle after halt_req=0; reset low mid-MEM of sw -> dmem_we=0 and state=IDLE at once.
